alu_seq_ctrl: RTL and testbench

//  Sequencer around one shared 8-bit add/sub datapath (A, B, select). Accepts one signed-operand command at a time.

---
 rtl/alu_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around one shared 8-bit add/sub datapath.
// Single-cycle arithmetic/logic ops plus an 8-iteration radix-2 Booth multiply.
module alu_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ovf,
  output logic                 zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NEG = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(6);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     m, m_n;
  logic [WIDTH-1:0]     rb, rb_n;
  logic [OP_W-1:0]      rop, rop_n;
  logic [WIDTH:0]       acc, acc_n;
  logic [WIDTH-1:0]     q, q_n;
  logic                 q1, q1_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2*WIDTH-1:0]   result_n;
  logic                 ovf_n, zero_n, done_n;

  logic [WIDTH:0]       add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_sel;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       acc_step;

  // One extra bit keeps the sum exact, so signed overflow is bit WIDTH vs bit WIDTH-1.
  assign add_sum = add_a + ({add_b[WIDTH-1], add_b} ^ {(WIDTH+1){add_sel}})
                 + {{WIDTH{1'b0}}, add_sel};

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      rb     <= '0;
      rop    <= '0;
      acc    <= '0;
      q      <= '0;
      q1     <= 1'b0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      m      <= m_n;
      rb     <= rb_n;
      rop    <= rop_n;
      acc    <= acc_n;
      q      <= q_n;
      q1     <= q1_n;
      cnt    <= cnt_n;
      result <= result_n;
      ovf    <= ovf_n;
      zero   <= zero_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    m_n      = m;
    rb_n     = rb;
    rop_n    = rop;
    acc_n    = acc;
    q_n      = q;
    q1_n     = q1;
    cnt_n    = cnt;
    result_n = result;
    ovf_n    = ovf;
    zero_n   = zero;
    done_n   = 1'b0;
    add_a    = '0;
    add_b    = '0;
    add_sel  = 1'b0;
    acc_step = '0;

    case (state)
      IDLE: begin
        if (start) begin
          m_n   = a;
          rb_n  = b;
          rop_n = op;
          if (op == OP_MUL) begin
            acc_n   = '0;
            q_n     = b;
            q1_n    = 1'b0;
            cnt_n   = '0;
            state_n = MUL;
          end else begin
            state_n = FIN;
          end
        end
      end

      FIN: begin
        done_n  = 1'b1;
        state_n = IDLE;
        ovf_n   = 1'b0;
        case (rop)
          OP_ADD: begin
            add_a = {m[WIDTH-1], m};
            add_b = rb;
          end
          OP_SUB: begin
            add_a   = {m[WIDTH-1], m};
            add_b   = rb;
            add_sel = 1'b1;
          end
          OP_NEG: begin
            add_b   = m;
            add_sel = 1'b1;
          end
          default: ;
        endcase
        case (rop)
          OP_ADD, OP_SUB, OP_NEG: begin
            result_n = {{WIDTH{add_sum[WIDTH-1]}}, add_sum[WIDTH-1:0]};
            ovf_n    = add_sum[WIDTH] ^ add_sum[WIDTH-1];
          end
          OP_AND:  result_n = {{WIDTH{1'b0}}, m & rb};
          OP_OR:   result_n = {{WIDTH{1'b0}}, m | rb};
          OP_XOR:  result_n = {{WIDTH{1'b0}}, m ^ rb};
          default: result_n = '0;
        endcase
        zero_n = (result_n == '0);
      end

      MUL: begin
        // Booth pair 10 subtracts M, 01 adds it; the adder subtracts only for 10.
        add_a    = acc;
        add_b    = m;
        add_sel  = q[0] & ~q1;
        acc_step = (q[0] ^ q1) ? add_sum : acc;
        acc_n    = {acc_step[WIDTH], acc_step[WIDTH:1]};
        q_n      = {acc_step[0], q[WIDTH-1:1]};
        q1_n     = q[0];
        cnt_n    = cnt + CW'(1);
        // The last iteration writes the product directly so done follows E8.
        if (cnt == CW'(WIDTH-1)) begin
          result_n = {acc_n[WIDTH-1:0], q_n};
          ovf_n    = 1'b0;
          zero_n   = (result_n == '0);
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed cases plus randomized commands
// checked against a plain-arithmetic reference model.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        busy, done, ovf, zero;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;
  int edgeCnt = 0;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        zero;
    int          due;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model straight from the opcode definitions using integer arithmetic.
  function automatic exp_t modelOp(input logic [2:0] o, input logic [7:0] av,
                                   input logic [7:0] bv);
    exp_t e;
    int sa, sv, s;
    logic [7:0] w;
    sa = int'($signed(av));
    sv = int'($signed(bv));
    s = 0;
    e.res = 16'h0000;
    e.ovf = 1'b0;
    e.due = 0;
    case (o)
      3'd0: s = sa + sv;
      3'd1: s = sa - sv;
      3'd5: s = -sa;
      3'd6: s = sa * sv;
      default: s = 0;
    endcase
    case (o)
      3'd0, 3'd1, 3'd5: begin
        w = s[7:0];
        e.res = {{8{w[7]}}, w};
        e.ovf = (s > 127) || (s < -128);
      end
      3'd2: e.res = {8'h00, av & bv};
      3'd3: e.res = {8'h00, av | bv};
      3'd4: e.res = {8'h00, av ^ bv};
      3'd6: e.res = s[15:0];
      default: e.res = 16'h0000;
    endcase
    e.zero = (e.res == 16'h0000);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious done", {31'd0, done}, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("result", {16'd0, result}, {16'd0, monE.res});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, monE.ovf});
        checkOutput("zero", {31'd0, zero}, {31'd0, monE.zero});
        checkOutput("done timing", edgeCnt, monE.due);
      end
    end else if (expQ.size() > 0 && edgeCnt > expQ[0].due) begin
      checkOutput("done timeout", edgeCnt, expQ[0].due);
      void'(expQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic s, input logic [2:0] o,
                               input logic [7:0] av, input logic [7:0] bv,
                               input logic useModel, input logic [15:0] er,
                               input logic eo, input logic ez);
    exp_t e;
    start = s;
    op = o;
    a = av;
    b = bv;
    if (s && !busy && rst_n) begin
      if (useModel) begin
        e = modelOp(o, av, bv);
      end else begin
        e.res = er;
        e.ovf = eo;
        e.zero = ez;
      end
      e.due = edgeCnt + 1 + ((o == 3'd6) ? 8 : 1);
      expQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40; i++) begin
      if (!busy && expQ.size() == 0) return;
      @(negedge clk);
    end
    checkOutput("idle timeout", {31'd0, busy}, 32'd0);
    expQ.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", {16'd0, result}, 32'd0);
    checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
    checkOutput("reset zero", {31'd0, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 3'd0, 8'd100, 8'd50, 1'b0, 16'hFF96, 1'b1, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 3'd1, 8'h80, 8'h01, 1'b0, 16'h007F, 1'b1, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 3'd5, 8'h80, 8'h37, 1'b0, 16'hFF80, 1'b1, 1'b0);
    waitIdle();

    applyStimulus(1'b1, 3'd6, 8'h80, 8'h80, 1'b0, 16'h4000, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mul busy cycles", n, 8);
    waitIdle();
    applyStimulus(1'b1, 3'd6, 8'd7, 8'hFD, 1'b0, 16'hFFEB, 1'b0, 1'b0);
    waitIdle();

    applyStimulus(1'b1, 3'd2, 8'hF0, 8'h3C, 1'b0, 16'h0030, 1'b0, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 3'd4, 8'h5A, 8'h5A, 1'b0, 16'h0000, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 3'd7, 8'hA5, 8'h3C, 1'b0, 16'h0000, 1'b0, 1'b1);
    waitIdle();

    // Starts during a multiply are dropped; a start in the done cycle is taken.
    applyStimulus(1'b1, 3'd6, 8'd5, 8'hF7, 1'b1, 16'h0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 3'd0, 8'd1, 8'd1, 1'b1, 16'h0, 1'b0, 1'b0);
    n = 0;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy in done cycle", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 3'd0, 8'd20, 8'd30, 1'b1, 16'h0, 1'b0, 1'b0);
    waitIdle();

    // Reset part way through a multiply abandons it without a done pulse.
    applyStimulus(1'b1, 3'd6, 8'h33, 8'h44, 1'b1, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid reset done", {31'd0, done}, 32'd0);
    checkOutput("mid reset result", {16'd0, result}, 32'd0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 1'b1, 16'h0, 1'b0, 1'b0);
    end
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
